sme_record_loader: RTL
======================

Name: sme_record_loader

Overview:
- Upstream feeder for the string-match engine.
- Accepts a ready/valid byte stream of tagged records (string or pattern), buffers one record, and replays it to the engine as a contiguous isstring/ispattern burst on chardata.
- After a pattern burst, waits for the engine's one-cycle valid pulse and holds the match result for the host.
- Enforces the engine's length limits and ordering rules, so the engine never sees overlong, interleaved or out-of-order input.

Parameters:
- STR_MAX, 32: maximum string length in bytes; longer records are truncated.
- PAT_MAX, 8: maximum pattern length in bytes; longer records are truncated.
- TIMEOUT, 1023: maximum cycles to wait for sme_valid after a pattern burst.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- in_valid  in  1  host byte valid.
- in_ready  out  1  loader can accept a byte.
- in_data  in  8  host byte.
- in_kind  in  1  record type, 0=string, 1=pattern; sampled on the first byte of a record only.
- in_last  in  1  last byte of the record.
- chardata  out  8  byte to the engine.
- isstring  out  1  string burst strobe to the engine.
- ispattern  out  1  pattern burst strobe to the engine.
- sme_valid  in  1  engine result pulse.
- sme_match  in  1  engine match flag.
- sme_index  in  5  engine match index.
- res_valid  out  1  one-cycle result pulse to the host.
- res_match  out  1  captured match flag.
- res_index  out  5  captured match index.
- err_ovf  out  1  sticky: a record exceeded its limit.
- err_nostr  out  1  sticky: a pattern arrived before any string.
- err_tmo  out  1  sticky: the engine did not respond within TIMEOUT.

Behaviour:
- Reset (async) clears:
  - outputs: in_ready=0, chardata=0, isstring=0, ispattern=0, res_valid=0, res_match=0, res_index=0, all err_* = 0.
  - internal: state=IDLE, buffer count=0, have_str=0.
- Reset asserted mid-burst or mid-wait aborts the burst immediately; partial buffer contents are discarded.
- All engine-side and host-side outputs are registered.

State IDLE/FILL:
- in_ready=1.
- A transfer occurs when in_valid&in_ready are both high on an edge.
- First byte of a record latches kind. Each byte is written to buf[cnt] and cnt increments while cnt<limit (limit = STR_MAX or PAT_MAX by kind).
- Bytes beyond the limit are accepted but dropped, and err_ovf is set.
- Transfer with in_last:
  - Go to SEND with len=min(count,limit).
  - If kind=pattern and have_str=0, go to NOSTR instead.

State SEND:
- in_ready=0.
- isstring (kind 0) or ispattern (kind 1) rises on the edge after the last-byte transfer.
- The strobe stays high for exactly len consecutive cycles, with chardata=buf[i] in burst cycle i (i=0..len-1).
- After the burst:
  - String: strobe and chardata go to 0, have_str=1, then return to IDLE.
  - Pattern: strobe and chardata go to 0, then go to WAIT with the timer cleared.
- Bursts are therefore separated by at least two strobe-low cycles. isstring and ispattern are never high together.

State WAIT:
- in_ready=0; the timer increments each cycle.
- On sme_valid=1: capture sme_match and sme_index into res_match/res_index, pulse res_valid for one cycle, return to IDLE.
- If the timer reaches TIMEOUT without sme_valid:
  - res_valid pulses with res_match=0, res_index=0; err_tmo is set; return to IDLE.
- If sme_valid coincides with the timeout cycle, sme_valid wins and err_tmo is not set.

State NOSTR:
- No burst is issued.
- One cycle later: res_valid pulses with res_match=0, res_index=0; err_nostr is set; return to IDLE.

Other rules:
- sme_valid outside WAIT is ignored; res_* hold their values.
- res_match/res_index hold until the next result.
- have_str persists across patterns, so several patterns may follow one string. A new string record replaces the previous string in the engine.
- in_kind changes within a record are ignored.
- A single-byte record (first byte also carries in_last) gives len=1.
- Widths:
  - cnt is 6 bits, which holds up to 32 and saturates at the limit.
  - timer is 10 bits.

Test Plan:
- String "ab cd" (5 bytes, last on 'd') then pattern "^cd" -> isstring high 5 cycles with bytes 61,62,20,63,64; then ispattern high 3 cycles with 5E,63,64; drive sme_valid with match=1, index=3 -> res_valid one pulse, res_match=1, res_index=3, in_ready=0 throughout SEND and WAIT.
- 40-byte string record -> isstring high exactly 32 cycles carrying bytes 0..31; err_ovf=1. 10-byte pattern -> ispattern high 8 cycles.
- Pattern record directly after reset -> no ispattern activity; res_valid pulse with res_match=0, res_index=0; err_nostr=1.
- Pattern burst with no sme_valid -> after 1023 WAIT cycles res_valid pulse with res_match=0, err_tmo=1, in_ready returns to 1. Repeat with sme_valid on the final cycle -> err_tmo stays 0.
- Reset asserted during burst cycle 3 of a string -> isstring drops asynchronously; next pattern gives err_nostr; in_valid pulses stalled during WAIT are not lost (host holds data until in_ready).
- One string followed by two patterns "a*d" and "x" -> two bursts, two res_valid pulses, captured values match the driven sme_match/sme_index for each.

Source files
------------

// File: rtl/sme_record_loader.sv
// sme_record_loader: upstream feeder for the string-match engine.
// Buffers one tagged record (string or pattern) from a ready/valid byte
// stream, replays it as a contiguous isstring/ispattern burst on chardata,
// then (for patterns) waits for the engine's result pulse and holds it for
// the host.
//
// Ports:
//   clk, reset                  clock, async active-high reset
//   in_valid/in_ready/in_data   host byte stream (ready/valid)
//   in_kind, in_last            record type (first byte only), end of record
//   chardata/isstring/ispattern burst to the engine
//   sme_valid/sme_match/sme_index  engine result
//   res_valid/res_match/res_index  result to the host
//   err_ovf/err_nostr/err_tmo   sticky error flags
module sme_record_loader #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_kind,
  input  logic       in_last,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_index,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       err_ovf,
  output logic       err_nostr,
  output logic       err_tmo
);

  localparam int         BUF_D    = (STR_MAX > PAT_MAX) ? STR_MAX : PAT_MAX;
  localparam int         AW       = (BUF_D > 1) ? $clog2(BUF_D) : 1;
  localparam logic [5:0] STR_LIM  = 6'(STR_MAX);
  localparam logic [5:0] PAT_LIM  = 6'(PAT_MAX);
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_NOSTR} state_t;

  state_t      state_q, state_d;
  logic        kind_q, kind_d;
  logic        rec_q, rec_d;          // inside a record (first byte seen)
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  len_q, len_d;
  logic [5:0]  idx_q, idx_d;
  logic [9:0]  timer_q, timer_d;
  logic        have_str_q, have_str_d;
  logic        in_ready_q, in_ready_d;
  logic [7:0]  chardata_q, chardata_d;
  logic        isstring_q, isstring_d;
  logic        ispattern_q, ispattern_d;
  logic        res_valid_q, res_valid_d;
  logic        res_match_q, res_match_d;
  logic [4:0]  res_index_q, res_index_d;
  logic        err_ovf_q, err_ovf_d;
  logic        err_nostr_q, err_nostr_d;
  logic        err_tmo_q, err_tmo_d;
  logic [7:0]  mem_q [BUF_D];
  logic [7:0]  mem_d [BUF_D];
  logic        cur_kind;
  logic [5:0]  limit;

  // Kind is taken from the wire only on a record's first byte.
  assign cur_kind = rec_q ? kind_q : in_kind;
  assign limit    = cur_kind ? PAT_LIM : STR_LIM;

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    rec_d       = rec_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    have_str_d  = have_str_q;
    in_ready_d  = in_ready_q;
    chardata_d  = chardata_q;
    isstring_d  = isstring_q;
    ispattern_d = ispattern_q;
    res_valid_d = 1'b0;
    res_match_d = res_match_q;
    res_index_d = res_index_q;
    err_ovf_d   = err_ovf_q;
    err_nostr_d = err_nostr_q;
    err_tmo_d   = err_tmo_q;
    mem_d       = mem_q;
    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          kind_d = cur_kind;
          rec_d  = 1'b1;
          if (cnt_q < limit) begin
            mem_d[cnt_q[AW-1:0]] = in_data;
            cnt_d = cnt_q + 6'd1;
          end else begin
            err_ovf_d = 1'b1;
          end
          if (in_last) begin
            len_d      = cnt_d;
            cnt_d      = 6'd0;
            rec_d      = 1'b0;
            idx_d      = 6'd0;
            in_ready_d = 1'b0;
            state_d    = (cur_kind && !have_str_q) ? S_NOSTR : S_SEND;
          end
        end
      end
      S_SEND: begin
        if (idx_q < len_q) begin
          chardata_d  = mem_q[idx_q[AW-1:0]];
          isstring_d  = ~kind_q;
          ispattern_d = kind_q;
          idx_d       = idx_q + 6'd1;
        end else begin
          chardata_d  = 8'd0;
          isstring_d  = 1'b0;
          ispattern_d = 1'b0;
          if (kind_q) begin
            state_d = S_WAIT;
            timer_d = 10'd0;
          end else begin
            have_str_d = 1'b1;
            in_ready_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      S_WAIT: begin
        // A result on the last allowed cycle still counts as a response.
        if (sme_valid) begin
          res_valid_d = 1'b1;
          res_match_d = sme_match;
          res_index_d = sme_index;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end else if (timer_q == TMO_LAST) begin
          res_valid_d = 1'b1;
          res_match_d = 1'b0;
          res_index_d = 5'd0;
          err_tmo_d   = 1'b1;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          timer_d = timer_q + 10'd1;
        end
      end
      S_NOSTR: begin
        res_valid_d = 1'b1;
        res_match_d = 1'b0;
        res_index_d = 5'd0;
        err_nostr_d = 1'b1;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      kind_q      <= 1'b0;
      rec_q       <= 1'b0;
      cnt_q       <= 6'd0;
      len_q       <= 6'd0;
      idx_q       <= 6'd0;
      timer_q     <= 10'd0;
      have_str_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      chardata_q  <= 8'd0;
      isstring_q  <= 1'b0;
      ispattern_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_match_q <= 1'b0;
      res_index_q <= 5'd0;
      err_ovf_q   <= 1'b0;
      err_nostr_q <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      rec_q       <= rec_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      have_str_q  <= have_str_d;
      in_ready_q  <= in_ready_d;
      chardata_q  <= chardata_d;
      isstring_q  <= isstring_d;
      ispattern_q <= ispattern_d;
      res_valid_q <= res_valid_d;
      res_match_q <= res_match_d;
      res_index_q <= res_index_d;
      err_ovf_q   <= err_ovf_d;
      err_nostr_q <= err_nostr_d;
      err_tmo_q   <= err_tmo_d;
    end
  end

  // Record storage needs no reset: the count says what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_ready  = in_ready_q;
  assign chardata  = chardata_q;
  assign isstring  = isstring_q;
  assign ispattern = ispattern_q;
  assign res_valid = res_valid_q;
  assign res_match = res_match_q;
  assign res_index = res_index_q;
  assign err_ovf   = err_ovf_q;
  assign err_nostr = err_nostr_q;
  assign err_tmo   = err_tmo_q;

endmodule
